mult_32_seq_ctrl: RTL and testbench

- Sequential shift-add controller for the 32x32 unsigned multiplier datapath; produces a 64-bit product as hi/lo.
- Owns the FSM, iteration counter, operand latch and 64-bit product/accumulator register.
- Drives a start/busy/done handshake so the ALU top level can share one multiplier across instructions.
- Replaces the single-shot combinational start input with a defined multi-cycle operation.

---
 rtl/mult_32_seq_ctrl.sv | 85 ++++++++
 tb/tb_mult_32_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mult_32_seq_ctrl.sv
// Sequential shift-add controller for the unsigned WIDTH x WIDTH multiplier.
// A start in IDLE runs WIDTH shift-add steps, then pulses done with a 2*WIDTH-bit product on hi/lo.
module mult_32_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] multiplicant,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic               last_iter;

    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // The extra top bit keeps the carry, so the final shifted product is exact.
    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, (product[0] ? mcand : '0)};

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_next unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            mcand   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= multiplicant;
                        product <= {{WIDTH{1'b0}}, multiplier};
                        count   <= '0;
                    end
                end
                RUN: begin
                    product <= {sum, product[WIDTH-1:1]};
                    count   <= count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign hi   = product[2*WIDTH-1:WIDTH];
    assign lo   = product[WIDTH-1:0];

endmodule

// File: tb/tb_mult_32_seq_ctrl.sv
// Self-checking bench for mult_32_seq_ctrl: directed corner cases plus random operands
// compared against a plain 64-bit multiplication reference.
module tb_mult_32_seq_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] multiplicant;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int tests_run;
    int tests_failed;

    mult_32_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicant (multiplicant),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // One full operation from IDLE; scramble changes the operand inputs once it is accepted.
    task automatic mult_op(input logic [31:0] a, input logic [31:0] b, input int scramble);
        logic [63:0] exp;
        int          busy_cnt;
        int          done_cnt;
        exp = ref_mul(a, b);
        @(negedge clk);
        start        = 1'b1;
        multiplier   = a;
        multiplicant = b;
        @(negedge clk);
        start = 1'b0;
        if (scramble == 1) begin
            multiplier   = '0;
            multiplicant = '0;
        end else if (scramble == 2) begin
            multiplier   = $urandom;
            multiplicant = $urandom;
        end
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check("result", {hi, lo}, exp);
            end
            if (!busy) break;
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cnt), 64'(WIDTH + 1));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("back_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("idle_hold", {hi, lo}, exp);
    endtask

    initial begin
        int ndone;
        int last_done;
        int nbusy;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicant = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_prod", {hi, lo}, 64'd0);
        reset = 1'b0;

        mult_op(32'd1, 32'd2, 0);
        mult_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("ffff_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        mult_op(32'h1234_5678, 32'h9ABC_DEF0, 1);
        check("mixed_prod", {hi, lo}, 64'h0B00_EA4E_242D_2080);

        // start held high: back-to-back operations, one done per WIDTH+2 cycles.
        ndone     = 0;
        last_done = -1;
        @(negedge clk);
        start        = 1'b1;
        multiplier   = 32'd0;
        multiplicant = 32'hDEAD_BEEF;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (done) begin
                check("stream_result", {hi, lo}, 64'd0);
                if (last_done >= 0) check("stream_interval", 64'(i - last_done), 64'(WIDTH + 2));
                last_done = i;
                ndone++;
            end
            if (!busy && ndone > 0) check("stream_idle_hold", {hi, lo}, 64'd0);
        end
        start = 1'b0;
        check("stream_dones", 64'(ndone), 64'd3);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("stream_idle", 64'(busy), 64'd0);

        // Reset in the middle of RUN abandons the operation without a done pulse.
        ndone = 0;
        @(negedge clk);
        start        = 1'b1;
        multiplier   = 32'd7;
        multiplicant = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_running", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_prod", {hi, lo}, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        mult_op(32'd3, 32'd5, 0);
        check("after_abort", {hi, lo}, 64'h0000_0000_0000_000F);

        // start and reset together: reset wins and the request is lost.
        nbusy = 0;
        @(negedge clk);
        start        = 1'b1;
        reset        = 1'b1;
        multiplier   = 32'd9;
        multiplicant = 32'd9;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done) nbusy++;
            @(negedge clk);
        end
        check("rst_start_busy", 64'(nbusy), 64'd0);
        check("rst_start_prod", {hi, lo}, 64'd0);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if (n % 5 == 0) a = 32'hFFFF_FFFF;
            if (n % 7 == 0) b = 32'd0;
            mult_op(a, b, (n % 3 == 0) ? 2 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
